// File: rtl/multiciclo_memory_responder.sv
// Word-organised RAM responder: one request at a time, WAIT_CYCLES+2 cycles to oReady (1 on reject).
// Requester holds iRead/iWrite until the single-cycle oReady pulse; new requests are taken only in IDLE.
module multiciclo_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iRead,
  input  logic        iWrite,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic [2:0]  iSize,
  output logic [31:0] oReadData,
  output logic        oReady,
  output logic        oBusy,
  output logic        oError
);

  typedef enum logic [1:0] {stIdle, stWait, stAccess, stRespond} state_t;

  localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                state, stateNext;
  logic [3:0]            count;
  logic                  errFlag;
  logic                  isWrite;
  logic [ADDR_WIDTH+1:0] addrQ;
  logic [2:0]            sizeQ;
  logic [31:0]           dataQ;
  logic                  request;
  logic                  reject;
  logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [31:0]           ramWord;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;
  logic [31:0]           loadValue;
  logic [3:0]            byteEn;
  logic [31:0]           writeWord;
  logic                  unusedAddrBits;

  assign unusedAddrBits = ^iAddress[31:ADDR_WIDTH+2];
  assign request        = iRead | iWrite;

  always_comb begin
    reject = 1'b0;
    if (iRead && iWrite) reject = 1'b1;
    if (iSize == 3'b011 || iSize[2:1] == 2'b11) reject = 1'b1;
    if (iWrite && iSize[2:1] == 2'b10) reject = 1'b1;
    // size[1:0] covers both signed and unsigned variants of H
    if (iSize[1:0] == 2'b01 && iAddress[0]) reject = 1'b1;
    if (iSize[1:0] == 2'b10 && iAddress[1:0] != 2'b00) reject = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= stIdle;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      stIdle: begin
        if (request) begin
          if (reject)                stateNext = stRespond;
          else if (WAIT_CYCLES == 0) stateNext = stAccess;
          else                       stateNext = stWait;
        end
      end
      stWait:    if (count == 4'd0) stateNext = stAccess;
      stAccess:  stateNext = stRespond;
      stRespond: stateNext = stIdle;
      default:   stateNext = stIdle;
    endcase
  end

  assign wordIdx = addrQ[ADDR_WIDTH+1:2];
  assign ramWord = mem[wordIdx];
  assign halfSel = addrQ[1] ? ramWord[31:16] : ramWord[15:0];

  always_comb begin
    byteSel = ramWord[7:0];
    case (addrQ[1:0])
      2'd1:    byteSel = ramWord[15:8];
      2'd2:    byteSel = ramWord[23:16];
      2'd3:    byteSel = ramWord[31:24];
      default: byteSel = ramWord[7:0];
    endcase
  end

  always_comb begin
    loadValue = ramWord;
    case (sizeQ)
      3'b000:  loadValue = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadValue = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadValue = {24'd0, byteSel};
      3'b101:  loadValue = {16'd0, halfSel};
      default: loadValue = ramWord;
    endcase
  end

  always_comb begin
    byteEn    = 4'b1111;
    writeWord = dataQ;
    case (sizeQ[1:0])
      2'b00: begin
        byteEn              = 4'b0000;
        byteEn[addrQ[1:0]]  = 1'b1;
        writeWord           = {4{dataQ[7:0]}};
      end
      2'b01: begin
        byteEn    = addrQ[1] ? 4'b1100 : 4'b0011;
        writeWord = {2{dataQ[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        writeWord = dataQ;
      end
    endcase
  end

  // RAM is deliberately unreset; an async reset drops the FSM out of ACCESS before the write edge
  always_ff @(posedge clock) begin
    if (state == stAccess && isWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= writeWord[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 4'd0;
      errFlag   <= 1'b0;
      isWrite   <= 1'b0;
      addrQ     <= '0;
      sizeQ     <= 3'd0;
      dataQ     <= 32'd0;
      oReadData <= 32'd0;
    end else begin
      case (state)
        stIdle: begin
          if (request) begin
            addrQ   <= iAddress[ADDR_WIDTH+1:0];
            sizeQ   <= iSize;
            dataQ   <= iWriteData;
            isWrite <= iWrite;
            errFlag <= reject;
            count   <= WaitInit;
            if (reject) oReadData <= 32'd0;
          end
        end
        stWait:   if (count != 4'd0) count <= count - 4'd1;
        stAccess: if (!isWrite) oReadData <= loadValue;
        default:  ;
      endcase
    end
  end

  assign oReady = (state == stRespond);
  assign oError = oReady & errFlag;
  assign oBusy  = (state != stIdle);

endmodule

// File: tb/tb_multiciclo_memory_responder.sv
// Directed bench: one responder with WAIT_CYCLES=2 and one with WAIT_CYCLES=0, selected by sel.
module tb_multiciclo_memory_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic        iRead = 1'b0, iWrite = 1'b0;
  logic [31:0] iAddress = 32'd0, iWriteData = 32'd0;
  logic [2:0]  iSize = 3'd0;

  logic [31:0] rdata2, rdata0;
  logic        rdy2, busy2, err2, rdy0, busy0, err0;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] rdata;
  logic        rdy, busy, err;

  int passCnt = 0;
  int totalCnt = 0;

  assign rd2   = iRead  & ~sel;
  assign wr2   = iWrite & ~sel;
  assign rd0   = iRead  &  sel;
  assign wr0   = iWrite &  sel;
  assign rdata = sel ? rdata0 : rdata2;
  assign rdy   = sel ? rdy0   : rdy2;
  assign busy  = sel ? busy0  : busy2;
  assign err   = sel ? err0   : err2;

  always #5 clock = ~clock;

  multiciclo_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .iRead(rd2), .iWrite(wr2),
    .iAddress(iAddress), .iWriteData(iWriteData), .iSize(iSize),
    .oReadData(rdata2), .oReady(rdy2), .oBusy(busy2), .oError(err2)
  );

  multiciclo_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .iRead(rd0), .iWrite(wr0),
    .iAddress(iAddress), .iWriteData(iWriteData), .iSize(iSize),
    .oReadData(rdata0), .oReady(rdy0), .oBusy(busy0), .oError(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives one request and holds it until oReady; lat counts edges from request to ready.
  task automatic doReq(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sz, output int lat, output logic e,
                       output logic [31:0] data, output logic busyOk);
    @(posedge clock); #1;
    iRead = r; iWrite = w; iAddress = a; iWriteData = d; iSize = sz;
    lat = 99; busyOk = 1'b1; e = 1'bx; data = 32'hxxxxxxxx;
    for (int i = 1; i <= 20 && lat == 99; i++) begin
      @(posedge clock); #1;
      if (rdy) begin
        lat = i; e = err; data = rdata;
      end else if (!busy) begin
        busyOk = 1'b0;
      end
    end
    iRead = 1'b0; iWrite = 1'b0;
  endtask

  initial begin
    int lat;
    logic e, bOk;
    logic [31:0] d;
    logic [7:0] rdyVec, busyVec;

    #2;
    chk("reset_ready", {31'd0, rdy2}, 32'd0);
    chk("reset_busy",  {31'd0, busy2}, 32'd0);
    chk("reset_error", {31'd0, err2}, 32'd0);
    chk("reset_rdata", rdata2, 32'd0);
    @(posedge clock); @(posedge clock); #1 reset_n = 1'b1;

    doReq(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, lat, e, d, bOk);
    chk("sw_latency", 32'(lat), 32'd4);
    chk("sw_error", {31'd0, e}, 32'd0);
    chk("sw_rdata_held", d, 32'd0);
    chk("sw_busy", {31'd0, bOk}, 32'd1);
    doReq(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, lat, e, d, bOk);
    chk("lw_latency", 32'(lat), 32'd4);
    chk("lw_data", d, 32'hDEADBEEF);

    doReq(1'b0, 1'b1, 32'h20, 32'h0, 3'b010, lat, e, d, bOk);
    doReq(1'b0, 1'b1, 32'h23, 32'h80, 3'b000, lat, e, d, bOk);
    chk("sb_held_rdata", d, 32'hDEADBEEF);
    doReq(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, lat, e, d, bOk);
    chk("sb_word", d, 32'h80000000);
    doReq(1'b1, 1'b0, 32'h23, 32'd0, 3'b000, lat, e, d, bOk);
    chk("lb_sign", d, 32'hFFFFFF80);
    doReq(1'b1, 1'b0, 32'h23, 32'd0, 3'b100, lat, e, d, bOk);
    chk("lbu_zero", d, 32'h00000080);
    doReq(1'b0, 1'b1, 32'h20, 32'hABCD1234, 3'b001, lat, e, d, bOk);
    doReq(1'b1, 1'b0, 32'h20, 32'd0, 3'b001, lat, e, d, bOk);
    chk("lh_low", d, 32'h00001234);
    doReq(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, lat, e, d, bOk);
    chk("sh_word", d, 32'h80001234);
    doReq(1'b1, 1'b0, 32'h22, 32'd0, 3'b001, lat, e, d, bOk);
    chk("lh_high_sign", d, 32'hFFFF8000);
    doReq(1'b1, 1'b0, 32'h22, 32'd0, 3'b101, lat, e, d, bOk);
    chk("lhu_high", d, 32'h00008000);

    doReq(1'b1, 1'b0, 32'h22, 32'd0, 3'b010, lat, e, d, bOk);
    chk("misaligned_lw_latency", 32'(lat), 32'd1);
    chk("misaligned_lw_error", {31'd0, e}, 32'd1);
    chk("misaligned_lw_rdata", d, 32'd0);
    doReq(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, lat, e, d, bOk);
    chk("ram_unchanged", d, 32'h80001234);
    chk("good_error_low", {31'd0, e}, 32'd0);
    doReq(1'b1, 1'b1, 32'h20, 32'd0, 3'b010, lat, e, d, bOk);
    chk("rd_wr_both_error", {31'd0, e}, 32'd1);
    doReq(1'b0, 1'b1, 32'h20, 32'h55, 3'b100, lat, e, d, bOk);
    chk("sbu_write_error", {31'd0, e}, 32'd1);
    doReq(1'b1, 1'b0, 32'h20, 32'd0, 3'b011, lat, e, d, bOk);
    chk("size011_error", {31'd0, e}, 32'd1);
    doReq(1'b1, 1'b0, 32'h21, 32'd0, 3'b001, lat, e, d, bOk);
    chk("odd_lh_error", {31'd0, e}, 32'd1);
    doReq(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, lat, e, d, bOk);
    chk("ram_after_rejects", d, 32'h80001234);

    doReq(1'b0, 1'b1, 32'h1004, 32'hCAFEF00D, 3'b010, lat, e, d, bOk);
    doReq(1'b1, 1'b0, 32'h0004, 32'd0, 3'b010, lat, e, d, bOk);
    chk("wrap_around", d, 32'hCAFEF00D);

    doReq(1'b0, 1'b1, 32'h40, 32'h22222222, 3'b010, lat, e, d, bOk);
    @(posedge clock); #1;
    iWrite = 1'b1; iAddress = 32'h40; iWriteData = 32'h11111111; iSize = 3'b010;
    @(posedge clock); #1;
    chk("midwrite_busy", {31'd0, busy2}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy2}, 32'd0);
    chk("midreset_rdata", rdata2, 32'd0);
    chk("midreset_ready", {30'd0, rdy2, err2}, 32'd0);
    iWrite = 1'b0;
    @(posedge clock); @(posedge clock); #1 reset_n = 1'b1;
    doReq(1'b1, 1'b0, 32'h40, 32'd0, 3'b010, lat, e, d, bOk);
    chk("aborted_write", d, 32'h22222222);

    sel = 1'b1;
    doReq(1'b0, 1'b1, 32'h8, 32'h55AA55AA, 3'b010, lat, e, d, bOk);
    chk("w0_sw_latency", 32'(lat), 32'd2);
    doReq(1'b1, 1'b0, 32'h8, 32'd0, 3'b010, lat, e, d, bOk);
    chk("w0_lw_latency", 32'(lat), 32'd2);
    chk("w0_lw_data", d, 32'h55AA55AA);
    chk("w0_busy", {31'd0, bOk}, 32'd1);

    // Held read: expect a second transaction starting in the IDLE cycle after RESPOND.
    @(posedge clock); #1;
    iRead = 1'b1; iAddress = 32'h8; iSize = 3'b010;
    rdyVec = 8'd0; busyVec = 8'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      rdyVec[7-i]  = rdy;
      busyVec[7-i] = busy;
      if (i == 4) iRead = 1'b0;
    end
    chk("held_ready_pattern", {24'd0, rdyVec}, 32'h00000048);
    chk("held_busy_pattern", {24'd0, busyVec}, 32'h000000D8);
    chk("held_data", rdata0, 32'h55AA55AA);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/multiciclo_memory_responder.md
# multiciclo_memory_responder

Memory-side responder for the multicycle RISC-V core. It accepts the read and write strobes, address and store data driven by the multicycle control datapath, and serves them from an internal word-organised RAM after a programmable number of wait states. It performs byte and halfword lane selection with sign or zero extension, and signals completion with a one-cycle ready pulse. It sits between the control/datapath and the unified instruction/data store, and replaces the zero-latency memory model.

## Interface

**Parameters**
- ADDR_WIDTH, 10: word-address bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2: wait states inserted before each access. Legal range is 0..15.

**Ports**
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iRead  in  1  read request; held high by the requester until oReady.
- iWrite  in  1  write request; held high by the requester until oReady.
- iAddress  in  32  byte address.
- iWriteData  in  32  store data; the low byte or halfword is used for SB/SH.
- iSize  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- oReadData  out  32  extended load result.
- oReady  out  1  one-cycle completion pulse.
- oBusy  out  1  high whenever the FSM is not in IDLE.
- oError  out  1  high together with oReady when the request was rejected.

## Operation

- **FSM states:** IDLE, WAIT, ACCESS, RESPOND.
- **IDLE:**
  - Samples a request when iRead|iWrite is high. On that edge it latches iAddress, iSize, iWriteData and the request type.
  - Reject conditions:
    - iRead&iWrite both high;
    - iSize is 011, 110 or 111;
    - iWrite with iSize 100 or 101;
    - halfword access with address[0]=1;
    - word access with address[1:0]≠00.
  - On reject: go to RESPOND with the error flag set. No RAM access is performed.
  - Otherwise: go to WAIT with counter = WAIT_CYCLES-1, or go directly to ACCESS when WAIT_CYCLES=0.
- **WAIT:** decrements the counter each cycle and goes to ACCESS when the counter reaches 0.
- **ACCESS:** one cycle.
  - Word index = address[ADDR_WIDTH+1:2]. Higher address bits are ignored, so accesses wrap modulo RAM size.
  - Write lanes:
    - B writes lane address[1:0];
    - H writes lanes {address[1],0} and {address[1],1};
    - W writes all four lanes.
  - Unwritten lanes are preserved.
  - Read: loads the selected lane(s), sign-extends for B/H, zero-extends for BU/HU, and registers the result into oReadData.
- **RESPOND:** oReady=1 for exactly one cycle, oError = the error flag; then return to IDLE unconditionally.
- **Request handling in RESPOND:** a request still high during RESPOND is ignored. If it is still high in IDLE on the next cycle, it is treated as a new request.
- **oReadData update rules:**
  - updated only by a successful read;
  - holds its previous value after a write;
  - set to 0 on an error response.
- **oBusy** = (state≠IDLE). Changes on iAddress, iSize or iWriteData after the sampling edge have no effect.

## Timing

- **Reset values:** with reset_n low, the block immediately enters IDLE and sets counter=0, error flag=0, oReady=0, oBusy=0, oError=0, oReadData=0. RAM contents are not cleared.
- **Reset mid-operation:** a request in WAIT or ACCESS is aborted. If reset_n falls before the edge ending ACCESS, the write does not occur.
- **Latency:**
  - Let E0 be the sampling edge. oReady is high in the cycle after edge E0+WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles after the request was first seen.
  - With WAIT_CYCLES=0, ready appears two cycles after the request.
  - Error responses: oReady and oError are high in the cycle after E0 (1 cycle latency).
- **Valid data:** oReadData is valid in the oReady cycle and stable until the next successful read or error response.
- **Throughput:** back-to-back requests are accepted no sooner than one IDLE cycle after RESPOND. Minimum request spacing is WAIT_CYCLES+3 cycles.
- **Ready/error coupling:** oReady and oError are never high outside RESPOND. oError is never high without oReady.

## Test plan

- **Word round trip, WAIT_CYCLES=2:**
  - SW 0xDEADBEEF to address 0x10 -> oReady exactly 4 cycles after request, oError=0, oReadData unchanged.
  - LW 0x10 -> oReadData=0xDEADBEEF with oReady.
- **Sub-word stores and loads** (after word 0x00000000 at 0x20):
  - SB 0x80 at 0x23 -> word reads 0x80000000.
  - LB 0x23 -> 0xFFFFFF80.
  - LBU 0x23 -> 0x00000080.
  - SH 0x1234 at 0x20 then LH 0x20 -> 0x00001234; word reads 0x80001234.
- **Rejects:**
  - LW 0x22 -> oReady+oError 1 cycle after request, oReadData=0, RAM unchanged.
  - iRead&iWrite together -> error.
  - SB with iSize=100 -> error.
- **Wrap-around, ADDR_WIDTH=10:** SW 0xCAFEF00D to 0x1004 -> LW 0x0004 returns 0xCAFEF00D.
- **Reset mid-write:** SW 0x11111111 to 0x40 over prior 0x22222222, reset_n pulsed low during WAIT -> outputs all 0 immediately; later LW 0x40 returns 0x22222222.
- **WAIT_CYCLES=0 and held request:**
  - LW returns 2 cycles after request.
  - Request held high through RESPOND -> exactly one extra access begins in the following IDLE cycle; oBusy high throughout each transaction.
